// File: rtl/adc_dac_pkg.sv
// Shared widths and capture state encoding for the ADC snapshot path.
package adc_dac_pkg;

  localparam int ADC_W    = 12;
  localparam int SAMPLE_W = 2 * ADC_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_WAIT,
    ST_POST,
    ST_DONE
  } cap_state_t;

endpackage

// File: rtl/adc_capture_if.sv
// Sample stream, trigger control and readback bundle between the host side and adc_capture.
interface adc_capture_if #(
  parameter int DEPTH_LOG2 = 10
);
  import adc_dac_pkg::*;

  logic signed [ADC_W-1:0] ad_data_ch0;
  logic signed [ADC_W-1:0] ad_data_ch1;
  logic                    sample_valid;
  logic                    arm;
  logic                    abort;
  logic                    trig_src;
  logic signed [ADC_W-1:0] trig_level;
  logic                    trig_force;
  logic [DEPTH_LOG2-1:0]   pre_len;
  logic                    busy;
  logic                    done;
  logic [DEPTH_LOG2-1:0]   start_addr;
  logic [DEPTH_LOG2-1:0]   rd_addr;
  logic [SAMPLE_W-1:0]     rd_data;

  modport master (
    output ad_data_ch0, ad_data_ch1, sample_valid, arm, abort,
           trig_src, trig_level, trig_force, pre_len, rd_addr,
    input  busy, done, start_addr, rd_data
  );

  modport slave (
    input  ad_data_ch0, ad_data_ch1, sample_valid, arm, abort,
           trig_src, trig_level, trig_force, pre_len, rd_addr,
    output busy, done, start_addr, rd_data
  );

endinterface

// File: rtl/capture_ram.sv
// Simple dual-port sample memory: synchronous write, registered synchronous read.
module capture_ram
  import adc_dac_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [SAMPLE_W-1:0] wdata,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [SAMPLE_W-1:0] rdata
);

  logic [SAMPLE_W-1:0] mem [(1 << ADDR_W)];

  always_ff @(posedge sys_clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the output register is reset; the array keeps its contents.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/adc_capture.sv
// Triggered snapshot buffer: records a DEPTH-pair window of {ch1, ch0} around a
// rising level crossing, keeping pre-trigger history by circular writing.
module adc_capture
  import adc_dac_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input logic          sys_clk,
  input logic          rst_n,
  adc_capture_if.slave cap
);

  localparam int                    CNT_W     = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0]      DEPTH_CNT = CNT_W'(1 << DEPTH_LOG2);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  cap_state_t              state_reg;
  logic [DEPTH_LOG2-1:0]   wr_ptr_reg;
  logic [DEPTH_LOG2-1:0]   pre_len_reg;
  logic [DEPTH_LOG2-1:0]   start_addr_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic signed [ADC_W-1:0] prev_reg;
  logic                    prev_ok_reg;
  logic                    busy_reg;
  logic                    done_reg;

  logic signed [ADC_W-1:0] cur;
  logic                    writing;
  logic                    crossing;
  logic                    trig_hit;
  logic [CNT_W-1:0]        post_total;
  logic [CNT_W-1:0]        cnt_inc;
  logic [SAMPLE_W-1:0]     rd_data_w;

  assign cur        = cap.trig_src ? $signed(cap.ad_data_ch1) : $signed(cap.ad_data_ch0);
  assign writing    = cap.sample_valid && !cap.abort &&
                      (state_reg == ST_PRE || state_reg == ST_WAIT || state_reg == ST_POST);
  assign crossing   = prev_ok_reg && (prev_reg < $signed(cap.trig_level)) &&
                      (cur >= $signed(cap.trig_level));
  assign trig_hit   = cap.trig_force || (cap.sample_valid && crossing);
  assign post_total = DEPTH_CNT - {1'b0, pre_len_reg};
  assign cnt_inc    = cnt_reg + CNT_ONE;

  // cnt_reg counts pre samples while in PRE and post samples while in POST.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      wr_ptr_reg     <= '0;
      pre_len_reg    <= '0;
      start_addr_reg <= '0;
      cnt_reg        <= '0;
      prev_reg       <= '0;
      prev_ok_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else if (cap.abort) begin
      state_reg <= ST_IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      if (writing) begin
        wr_ptr_reg  <= wr_ptr_reg + PTR_ONE;
        prev_reg    <= cur;
        prev_ok_reg <= 1'b1;
      end
      unique case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (cap.arm) begin
            wr_ptr_reg  <= '0;
            pre_len_reg <= cap.pre_len;
            prev_ok_reg <= 1'b0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b1;
            done_reg    <= 1'b0;
            state_reg   <= (cap.pre_len == '0) ? ST_WAIT : ST_PRE;
          end
        end
        ST_PRE: begin
          if (cap.sample_valid) begin
            if (cnt_inc == {1'b0, pre_len_reg}) begin
              cnt_reg   <= '0;
              state_reg <= ST_WAIT;
            end else begin
              cnt_reg <= cnt_inc;
            end
          end
        end
        ST_WAIT: begin
          if (trig_hit) begin
            start_addr_reg <= wr_ptr_reg - pre_len_reg;
            if (!cap.sample_valid) begin
              cnt_reg   <= '0;
              state_reg <= ST_POST;
            end else if (post_total == CNT_ONE) begin
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= ST_DONE;
            end else begin
              cnt_reg   <= CNT_ONE;
              state_reg <= ST_POST;
            end
          end
        end
        ST_POST: begin
          if (cap.sample_valid) begin
            if (cnt_inc == post_total) begin
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= ST_DONE;
            end else begin
              cnt_reg <= cnt_inc;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  capture_ram #(
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .we      (writing),
    .waddr   (wr_ptr_reg),
    .wdata   ({cap.ad_data_ch1, cap.ad_data_ch0}),
    .raddr   (cap.rd_addr),
    .rdata   (rd_data_w)
  );

  assign cap.busy       = busy_reg;
  assign cap.done       = done_reg;
  assign cap.start_addr = start_addr_reg;
  assign cap.rd_data    = rd_data_w;

endmodule

// File: tb/tb_adc_capture.sv
// Bench for adc_capture: directed and randomized captures checked against a
// sample-index model of where the trigger and window should land.
module tb_adc_capture;
  import adc_dac_pkg::*;

  localparam int DL    = 4;
  localparam int DEPTH = 1 << DL;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 sys_clk = ~sys_clk;

  adc_capture_if #(.DEPTH_LOG2(DL)) bus ();

  adc_capture #(.DEPTH_LOG2(DL)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .cap     (bus)
  );

  int total = 0;
  int bad   = 0;
  int s0[$];
  int s1[$];
  int fed;
  int done_at;
  int rb0[DEPTH];
  int rb1[DEPTH];

  function automatic logic [ADC_W-1:0] to12(input int v);
    return v[ADC_W-1:0];
  endfunction

  function automatic int rnd_sample();
    return int'($urandom_range(600)) - 300;
  endfunction

  // First sample index that satisfies the crossing rule once PRE is complete.
  function automatic int model_trig(input int pre, input int lvl, input bit src);
    for (int k = (pre > 1) ? pre : 1; k < s0.size(); k++) begin
      int p;
      int c;
      p = src ? s1[k-1] : s0[k-1];
      c = src ? s1[k] : s0[k];
      if (p < lvl && c >= lvl) return k;
    end
    return -1;
  endfunction

  task automatic cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic feed(input int idx);
    bus.sample_valid = 1'b1;
    bus.ad_data_ch0  = to12(s0[idx]);
    bus.ad_data_ch1  = to12(s1[idx]);
    cycle();
    bus.sample_valid = 1'b0;
  endtask

  task automatic junk(input logic valid);
    bus.sample_valid = valid;
    bus.ad_data_ch0  = to12(rnd_sample());
    bus.ad_data_ch1  = to12(rnd_sample());
    cycle();
    bus.sample_valid = 1'b0;
  endtask

  task automatic do_arm(input int pre);
    bus.pre_len = pre[DL-1:0];
    bus.arm     = 1'b1;
    cycle();
    bus.arm     = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.abort = 1'b1;
    cycle();
    bus.abort = 1'b0;
  endtask

  task automatic make_ramp();
    s0.delete();
    s1.delete();
    for (int v = -100; v <= 150; v += 10) begin
      s0.push_back(v);
      s1.push_back(rnd_sample());
    end
  endtask

  // Feeds s0/s1 with valid every gap cycles; done_at = samples fed when done rose.
  task automatic run_stream(input int gap, input int max_cyc);
    fed     = 0;
    done_at = -1;
    for (int c = 0; c < max_cyc && fed < s0.size() && done_at < 0; c++) begin
      if (c % gap == 0) begin
        feed(fed);
        fed++;
      end else begin
        junk(1'b0);
      end
      if (bus.done === 1'b1) done_at = fed;
    end
    if (done_at >= 0) repeat (3) junk(1'b1);
  endtask

  task automatic readback(input int base);
    for (int i = 0; i < DEPTH; i++) begin
      bus.rd_addr = DL'((base + i) % DEPTH);
      cycle();
      rb0[i] = int'($signed(bus.rd_data[ADC_W-1:0]));
      rb1[i] = int'($signed(bus.rd_data[SAMPLE_W-1:ADC_W]));
    end
  endtask

  task automatic test_reset();
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.start_addr !== '0 || bus.rd_data !== '0) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b done=%b start=%0d rd=%h, expected all zero",
               bus.busy, bus.done, bus.start_addr, bus.rd_data);
    end
    rst_n = 1'b1;
    cycle();
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: busy=%b done=%b, expected 0 0", bus.busy, bus.done);
    end
    $display("reset: checked");
  endtask

  task automatic test_basic(input int gap, input string tag);
    int trig;
    make_ramp();
    bus.trig_level = to12(0);
    bus.trig_src   = 1'b0;
    do_arm(4);
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL %s_busy_after_arm: got %b expected 1", tag, bus.busy);
    end
    run_stream(gap, 200);
    trig = model_trig(4, 0, 1'b0);
    total++;
    if (done_at !== trig + DEPTH - 4) begin
      bad++;
      $display("FAIL %s_done_at: got %0d expected %0d", tag, done_at, trig + DEPTH - 4);
    end
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.start_addr !== DL'(trig - 4)) begin
      bad++;
      $display("FAIL %s_final: busy=%b done=%b start=%0d expected 0 1 %0d",
               tag, bus.busy, bus.done, bus.start_addr, (trig - 4) % DEPTH);
    end
    readback(trig - 4);
    total++;
    if (rb0[0] !== -40 || rb0[DEPTH-1] !== 110) begin
      bad++;
      $display("FAIL %s_ends: got %0d..%0d expected -40..110", tag, rb0[0], rb0[DEPTH-1]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (rb0[i] !== s0[trig-4+i] || rb1[i] !== s1[trig-4+i]) begin
        bad++;
        $display("FAIL %s_rd[%0d]: got %0d/%0d expected %0d/%0d", tag, i, rb0[i], rb1[i],
                 s0[trig-4+i], s1[trig-4+i]);
      end
    end
    $display("%s: trig=%0d done_at=%0d start=%0d", tag, trig, done_at, bus.start_addr);
  endtask

  task automatic test_boundary();
    int trig;
    // Leave a negative prev behind so a missing prev_ok clear would fire on sample 0.
    bus.trig_level = to12(0);
    bus.trig_src   = 1'b0;
    do_arm(0);
    bus.sample_valid = 1'b1;
    bus.ad_data_ch0  = to12(-20);
    cycle();
    bus.sample_valid = 1'b0;
    pulse_abort();
    s0 = '{5, 3, 0, 0, -1, 0};
    s1 = '{1, 2, 3, 4, 5, 6};
    for (int i = 0; i < 20; i++) begin
      s0.push_back(rnd_sample());
      s1.push_back(rnd_sample());
    end
    do_arm(0);
    run_stream(1, 200);
    trig = model_trig(0, 0, 1'b0);
    total++;
    if (bus.start_addr !== DL'(5)) begin
      bad++;
      $display("FAIL bound_start: got %0d expected 5", bus.start_addr);
    end
    total++;
    if (done_at !== trig + DEPTH) begin
      bad++;
      $display("FAIL bound_done_at: got %0d expected %0d", done_at, trig + DEPTH);
    end
    readback(trig);
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (rb0[i] !== s0[trig+i] || rb1[i] !== s1[trig+i]) begin
        bad++;
        $display("FAIL bound_rd[%0d]: got %0d/%0d expected %0d/%0d", i, rb0[i], rb1[i],
                 s0[trig+i], s1[trig+i]);
      end
    end
    $display("boundary: trig=%0d start=%0d", trig, bus.start_addr);
  endtask

  task automatic test_force();
    int got_done;
    s0.delete();
    s1.delete();
    for (int i = 0; i < 30; i++) begin
      s0.push_back(-50);
      s1.push_back(rnd_sample());
    end
    bus.trig_level = to12(0);
    bus.trig_src   = 1'b0;
    do_arm(4);
    feed(0);
    bus.trig_force = 1'b1;
    feed(1);
    bus.trig_force = 1'b0;
    for (int i = 2; i < 6; i++) feed(i);
    total++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL force_wait: busy=%b done=%b expected 1 0", bus.busy, bus.done);
    end
    bus.trig_force = 1'b1;
    cycle();
    bus.trig_force = 1'b0;
    got_done = -1;
    for (int i = 6; i < 18; i++) begin
      feed(i);
      if (bus.done === 1'b1 && got_done < 0) got_done = i - 5;
    end
    total++;
    if (got_done !== DEPTH - 4) begin
      bad++;
      $display("FAIL force_post_count: got %0d expected %0d", got_done, DEPTH - 4);
    end
    total++;
    if (bus.start_addr !== DL'(2)) begin
      bad++;
      $display("FAIL force_start: got %0d expected 2", bus.start_addr);
    end
    readback(2);
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (rb0[i] !== s0[2+i] || rb1[i] !== s1[2+i]) begin
        bad++;
        $display("FAIL force_rd[%0d]: got %0d/%0d expected %0d/%0d", i, rb0[i], rb1[i],
                 s0[2+i], s1[2+i]);
      end
    end
    $display("force: post_count=%0d start=%0d", got_done, bus.start_addr);
  endtask

  task automatic test_abort();
    int trig;
    make_ramp();
    bus.trig_level = to12(0);
    bus.trig_src   = 1'b0;
    do_arm(4);
    for (int i = 0; i < 13; i++) feed(i);
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre_busy: got %b expected 1", bus.busy);
    end
    pulse_abort();
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL abort_mid_post: busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    bus.arm   = 1'b1;
    bus.abort = 1'b1;
    cycle();
    bus.arm   = 1'b0;
    bus.abort = 1'b0;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_with_arm: busy=%b expected 0", bus.busy);
    end
    do_arm(4);
    run_stream(1, 200);
    trig = model_trig(4, 0, 1'b0);
    total++;
    if (done_at !== trig + DEPTH - 4 || bus.start_addr !== DL'(trig - 4)) begin
      bad++;
      $display("FAIL abort_rearm: done_at=%0d start=%0d expected %0d %0d", done_at,
               bus.start_addr, trig + DEPTH - 4, trig - 4);
    end
    readback(trig - 4);
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (rb0[i] !== s0[trig-4+i] || rb1[i] !== s1[trig-4+i]) begin
        bad++;
        $display("FAIL abort_rd[%0d]: got %0d/%0d expected %0d/%0d", i, rb0[i], rb1[i],
                 s0[trig-4+i], s1[trig-4+i]);
      end
    end
    pulse_abort();
    total++;
    if (bus.done !== 1'b0) begin
      bad++;
      $display("FAIL abort_clears_done: done=%b expected 0", bus.done);
    end
    $display("abort: rearm done_at=%0d", done_at);
  endtask

  task automatic test_wrap();
    int trig;
    s0.delete();
    s1.delete();
    for (int i = 0; i < 44; i++) s0.push_back(-50);
    for (int i = 0; i < 20; i++) s0.push_back(10 * i);
    for (int i = 0; i < 64; i++) s1.push_back(rnd_sample());
    bus.trig_level = to12(0);
    bus.trig_src   = 1'b0;
    do_arm(4);
    done_at = -1;
    for (int i = 0; i < s0.size() && done_at < 0; i++) begin
      bus.arm = (i == 20);
      feed(i);
      bus.arm = 1'b0;
      if (bus.done === 1'b1) done_at = i + 1;
    end
    trig = model_trig(4, 0, 1'b0);
    total++;
    if (done_at !== trig + DEPTH - 4) begin
      bad++;
      $display("FAIL wrap_done_at: got %0d expected %0d", done_at, trig + DEPTH - 4);
    end
    total++;
    if (bus.start_addr !== DL'(8)) begin
      bad++;
      $display("FAIL wrap_start: got %0d expected 8", bus.start_addr);
    end
    readback(trig - 4);
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (rb0[i] !== s0[trig-4+i] || rb1[i] !== s1[trig-4+i]) begin
        bad++;
        $display("FAIL wrap_rd[%0d]: got %0d/%0d expected %0d/%0d", i, rb0[i], rb1[i],
                 s0[trig-4+i], s1[trig-4+i]);
      end
    end
    $display("wrap: trig=%0d start=%0d", trig, bus.start_addr);
  endtask

  task automatic test_async_reset();
    make_ramp();
    bus.rd_addr = '0;
    do_arm(4);
    for (int i = 0; i < 14; i++) feed(i);
    total++;
    if (bus.busy !== 1'b1 || bus.rd_data === '0 || bus.start_addr !== DL'(6)) begin
      bad++;
      $display("FAIL async_pre: busy=%b rd=%h start=%0d expected 1 nonzero 6",
               bus.busy, bus.rd_data, bus.start_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.start_addr !== '0 || bus.rd_data !== '0) begin
      bad++;
      $display("FAIL async_reset: busy=%b done=%b start=%0d rd=%h expected all zero",
               bus.busy, bus.done, bus.start_addr, bus.rd_data);
    end
    #3 rst_n = 1'b1;
    cycle();
    readback(0);
    for (int i = 0; i < 14; i++) begin
      total++;
      if (rb0[i] !== s0[i] || rb1[i] !== s1[i]) begin
        bad++;
        $display("FAIL async_retain[%0d]: got %0d/%0d expected %0d/%0d", i, rb0[i], rb1[i],
                 s0[i], s1[i]);
      end
    end
    $display("async_reset: checked");
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int pre;
      int lvl;
      int gap;
      int trig;
      int post;
      bit src;
      pre = int'($urandom_range(DEPTH - 1));
      lvl = int'($urandom_range(400)) - 200;
      gap = 1 + int'($urandom_range(2));
      src = 1'($urandom_range(1));
      s0.delete();
      s1.delete();
      for (int i = 0; i < 60; i++) begin
        s0.push_back(rnd_sample());
        s1.push_back(rnd_sample());
      end
      pulse_abort();
      bus.trig_level = to12(lvl);
      bus.trig_src   = src;
      bus.trig_force = 1'b0;
      do_arm(pre);
      run_stream(gap, 400);
      trig = model_trig(pre, lvl, src);
      post = DEPTH - pre;
      if (trig >= 0 && trig + post <= 60) begin
        total++;
        if (done_at !== trig + post || bus.start_addr !== DL'(trig - pre)) begin
          bad++;
          $display("FAIL rand%0d_done: done_at=%0d start=%0d expected %0d %0d", it, done_at,
                   bus.start_addr, trig + post, (trig - pre) % DEPTH);
        end
        readback(trig - pre);
        for (int i = 0; i < DEPTH; i++) begin
          total++;
          if (rb0[i] !== s0[trig-pre+i] || rb1[i] !== s1[trig-pre+i]) begin
            bad++;
            $display("FAIL rand%0d_rd[%0d]: got %0d/%0d expected %0d/%0d", it, i, rb0[i],
                     rb1[i], s0[trig-pre+i], s1[trig-pre+i]);
          end
        end
      end else begin
        total++;
        if (done_at !== -1 || bus.busy !== 1'b1) begin
          bad++;
          $display("FAIL rand%0d_pending: done_at=%0d busy=%b expected -1 1", it, done_at,
                   bus.busy);
        end
      end
      $display("random[%0d]: pre=%0d lvl=%0d src=%0d gap=%0d trig=%0d done_at=%0d",
               it, pre, lvl, src, gap, trig, done_at);
    end
  endtask

  initial begin
    bus.ad_data_ch0  = '0;
    bus.ad_data_ch1  = '0;
    bus.sample_valid = 1'b0;
    bus.arm          = 1'b0;
    bus.abort        = 1'b0;
    bus.trig_src     = 1'b0;
    bus.trig_level   = '0;
    bus.trig_force   = 1'b0;
    bus.pre_len      = '0;
    bus.rd_addr      = '0;
    repeat (3) cycle();
    test_reset();
    test_basic(1, "basic");
    test_basic(3, "sparse");
    test_boundary();
    test_force();
    test_abort();
    test_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
